// File: rtl/vt_stream_parser.sv
// Byte-stream terminal parser: turns received bytes into character-buffer writes for an
// 80x30 text screen, with CR/LF/BS, CSI cursor/erase commands and circular scrolling.
module vt_stream_parser #(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        wr_en_o,
  output logic [11:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic [4:0]  top_row_o,
  output logic [4:0]  cursor_row_o,
  output logic [6:0]  cursor_col_o,
  output logic        busy_o,
  output logic        overflow_o
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [11:0] CELLS    = 12'(ROWS * COLS);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);

  typedef enum logic [2:0] {S_GROUND, S_ESC, S_CSI, S_WRAP, S_CLEAR} state_t;

  state_t        state_q, state_d;
  logic [7:0]    p1_q, p1_d, p2_q, p2_d;
  logic [1:0]    idx_q, idx_d;
  logic [4:0]    row_q, row_d, top_q, top_d;
  logic [6:0]    col_q, col_d;
  logic [11:0]   clr_addr_q, clr_addr_d, clr_end_q, clr_end_d;
  logic          wr_en_q, wr_en_d;
  logic [11:0]   wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          ovf_q;
  logic          do_scroll;

  // Input FIFO; pops are held off while a clear sweep or wrap-scroll owns the write port.
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_empty, fifo_full, pop, push;
  logic [7:0]    byte_in;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && ((state_q == S_GROUND) || (state_q == S_ESC) || (state_q == S_CSI));
  assign push       = in_valid_i && (!fifo_full || pop);
  assign byte_in    = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= in_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (in_valid_i && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  // Both operands are below ROWS, so one conditional subtract performs the modulo.
  logic [5:0]  phys_sum;
  logic [4:0]  phys_row;
  logic [11:0] cur_addr, row_base;
  assign phys_sum = {1'b0, top_q} + {1'b0, row_q};
  assign phys_row = (phys_sum >= 6'(ROWS)) ? 5'(phys_sum - 6'(ROWS)) : phys_sum[4:0];
  assign cur_addr = 12'(phys_row) * 12'(COLS) + 12'(col_q);
  assign row_base = 12'(top_q) * 12'(COLS);

  logic [7:0]  n1, n2, h1, h2, p1_dig, p2_dig;
  logic [11:0] acc1, acc2;
  logic [8:0]  down_sum, right_sum;
  logic [4:0]  up_row, down_row, abs_row;
  logic [6:0]  left_col, right_col, abs_col;
  logic        is_digit;

  assign is_digit  = (byte_in >= "0") && (byte_in <= "9");
  assign acc1      = 12'(p1_q) * 12'd10 + 12'(byte_in[3:0]);
  assign acc2      = 12'(p2_q) * 12'd10 + 12'(byte_in[3:0]);
  assign p1_dig    = (acc1 > 12'd255) ? 8'hFF : acc1[7:0];
  assign p2_dig    = (acc2 > 12'd255) ? 8'hFF : acc2[7:0];
  assign n1        = (p1_q == 8'd0) ? 8'd1 : p1_q;
  assign n2        = (p2_q == 8'd0) ? 8'd1 : p2_q;
  assign h1        = n1 - 8'd1;
  assign h2        = n2 - 8'd1;
  assign down_sum  = 9'(row_q) + 9'(n1);
  assign right_sum = 9'(col_q) + 9'(n1);
  assign up_row    = (n1 > {3'b000, row_q}) ? 5'd0 : row_q - n1[4:0];
  assign down_row  = (down_sum > 9'(LAST_ROW)) ? LAST_ROW : down_sum[4:0];
  assign left_col  = (n1 > {1'b0, col_q}) ? 7'd0 : col_q - n1[6:0];
  assign right_col = (right_sum > 9'(LAST_COL)) ? LAST_COL : right_sum[6:0];
  assign abs_row   = (h1 > 8'(LAST_ROW)) ? LAST_ROW : h1[4:0];
  assign abs_col   = (h2 > 8'(LAST_COL)) ? LAST_COL : h2[6:0];

  always_comb begin
    state_d    = state_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    idx_d      = idx_q;
    row_d      = row_q;
    col_d      = col_q;
    top_d      = top_q;
    clr_addr_d = clr_addr_q;
    clr_end_d  = clr_end_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    do_scroll  = 1'b0;
    case (state_q)
      S_GROUND: if (pop) begin
        if ((byte_in >= 8'h20) && (byte_in <= 8'h7E)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cur_addr;
          wr_data_d = byte_in;
          if (col_q == LAST_COL) begin
            col_d = '0;
            // Bottom-row wrap: the scroll needs the write port, so it runs next cycle.
            if (row_q == LAST_ROW) state_d = S_WRAP;
            else                   row_d   = row_q + 5'd1;
          end else begin
            col_d = col_q + 7'd1;
          end
        end else begin
          case (byte_in)
            8'h0A: if (row_q == LAST_ROW) do_scroll = 1'b1;
                   else                   row_d     = row_q + 5'd1;
            8'h0D: col_d = '0;
            8'h08: if (col_q != '0) col_d = col_q - 7'd1;
            8'h1B: state_d = S_ESC;
            default: ;
          endcase
        end
      end
      S_ESC: if (pop) begin
        if (byte_in == "[") begin
          p1_d    = '0;
          p2_d    = '0;
          idx_d   = '0;
          state_d = S_CSI;
        end else begin
          state_d = S_GROUND;
        end
      end
      S_CSI: if (pop) begin
        if (is_digit) begin
          if (idx_q == 2'd0)      p1_d = p1_dig;
          else if (idx_q == 2'd1) p2_d = p2_dig;
        end else if (byte_in == ";") begin
          if (idx_q != 2'd2) idx_d = idx_q + 2'd1;
        end else if (byte_in < 8'h20) begin
          state_d = S_GROUND;
        end else if ((byte_in >= 8'h40) && (byte_in <= 8'h7E)) begin
          state_d = S_GROUND;
          case (byte_in)
            "A":     row_d = up_row;
            "B":     row_d = down_row;
            "C":     col_d = right_col;
            "D":     col_d = left_col;
            "H", "f": begin
              row_d = abs_row;
              col_d = abs_col;
            end
            "J": if (p1_q == 8'd2) begin
              state_d    = S_CLEAR;
              wr_en_d    = 1'b1;
              wr_addr_d  = '0;
              wr_data_d  = 8'h20;
              clr_addr_d = 12'd1;
              clr_end_d  = CELLS;
            end
            default: ;
          endcase
        end
      end
      S_WRAP: do_scroll = 1'b1;
      S_CLEAR: begin
        if (clr_addr_q != clr_end_q) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = clr_addr_q;
          wr_data_d  = 8'h20;
          clr_addr_d = clr_addr_q + 12'd1;
        end else begin
          state_d = S_GROUND;
        end
      end
      default: state_d = S_GROUND;
    endcase
    // The old top physical row becomes the new bottom row and is blanked.
    if (do_scroll) begin
      top_d      = (top_q == LAST_ROW) ? 5'd0 : top_q + 5'd1;
      wr_en_d    = 1'b1;
      wr_addr_d  = row_base;
      wr_data_d  = 8'h20;
      clr_addr_d = row_base + 12'd1;
      clr_end_d  = row_base + 12'(COLS);
      state_d    = S_CLEAR;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_GROUND;
      p1_q       <= '0;
      p2_q       <= '0;
      idx_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      top_q      <= '0;
      clr_addr_q <= '0;
      clr_end_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      col_q      <= col_d;
      top_q      <= top_d;
      clr_addr_q <= clr_addr_d;
      clr_end_q  <= clr_end_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign top_row_o    = top_q;
  assign cursor_row_o = row_q;
  assign cursor_col_o = col_q;
  assign busy_o       = (state_q == S_CLEAR);
  assign overflow_o   = ovf_q;
endmodule

// File: tb/tb_vt_stream_parser.sv
// Bench for vt_stream_parser: vector table for single-byte behaviour, a write scoreboard,
// and hand-written scroll / erase / FIFO-overflow / reset-mid-sweep sequences.
module tb_vt_stream_parser;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  top_row, cursor_row;
  logic [6:0]  cursor_col;
  logic        busy, overflow;

  vt_stream_parser #(.COLS(80), .ROWS(30), .FIFO_DEPTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .top_row_o(top_row),
    .cursor_row_o(cursor_row), .cursor_col_o(cursor_col), .busy_o(busy), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { logic [7:0] b; bit wr; int addr; int row; int col; } vec_t;

  wr_t  sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;
  int   busy_cnt = 0;
  bit   mon_en = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (mon_en && wr_en) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr %0d data %0h with empty scoreboard", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", int'(wr_addr), e.addr);
        chk("wr_data", int'(wr_data), e.data);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic expect_wr(input int addr, input int data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_top_row", int'(top_row), 0);
    chk("rst_cursor_row", int'(cursor_row), 0);
    chk("rst_cursor_col", int'(cursor_col), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_busy_low(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", limit);
    end
  endtask

  function automatic void add(input logic [7:0] b, input bit wr, input int addr, input int row, input int col);
    vec_t v;
    v.b = b; v.wr = wr; v.addr = addr; v.row = row; v.col = col;
    vecs.push_back(v);
  endfunction

  // ESC + body: cursor unchanged until the final byte of body.
  function automatic void add_csi(input string body, input int r0, input int c0, input int r1, input int c1);
    add(8'h1B, 1'b0, 0, r0, c0);
    for (int i = 0; i < body.len() - 1; i++) add(body[i], 1'b0, 0, r0, c0);
    add(body[body.len() - 1], 1'b0, 0, r1, c1);
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    add("H", 1, 0, 0, 1);      add("i", 1, 1, 0, 2);
    add(8'h08, 0, 0, 0, 1);    add("j", 1, 1, 0, 2);
    add(8'h0D, 0, 0, 0, 0);    add(8'h0A, 0, 0, 1, 0);
    add("k", 1, 80, 1, 1);     add(8'h07, 0, 0, 1, 1);
    add(8'h7F, 0, 0, 1, 1);    add(" ", 1, 81, 1, 2);
    add("~", 1, 82, 1, 3);
    add_csi("[3B", 1, 3, 4, 3);
    add_csi("[C", 4, 3, 4, 4);
    add_csi("[999C", 4, 4, 4, 79);
    add("m", 1, 399, 5, 0);
    add_csi("[D", 5, 0, 5, 0);
    add_csi("x", 5, 0, 5, 0);
    add("n", 1, 400, 5, 1);
    add_csi("[2", 5, 1, 5, 1);
    add(8'h0A, 0, 0, 5, 1);
    add("o", 1, 401, 5, 2);
    add_csi("[3J", 5, 2, 5, 2);
    add_csi("[7;3f", 5, 2, 6, 2);
    add_csi("[;5H", 6, 2, 0, 4);
    add_csi("[1;2;3H", 0, 4, 0, 1);
    add_csi("[Z", 0, 1, 0, 1);
    add("p", 1, 1, 0, 2);
    add("[", 1, 2, 0, 3);

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);

    // Printable text and first-write latency
    do_reset();
    expect_wr(0, 8'h41);
    expect_wr(1, 8'h42);
    send("A");
    chk("latency_wr_en_c1", int'(wr_en), 0);
    @(negedge clk);
    chk("latency_wr_en_c2", int'(wr_en), 1);
    send("B");
    repeat (3) @(negedge clk);
    chk("ab_col", int'(cursor_col), 2);
    chk("ab_sb_empty", sb.size(), 0);

    // Vector table
    do_reset();
    foreach (vecs[i]) begin
      if (vecs[i].wr) expect_wr(vecs[i].addr, int'(vecs[i].b));
      send(vecs[i].b);
      repeat (3) @(negedge clk);
      chk("vec_row", int'(cursor_row), vecs[i].row);
      chk("vec_col", int'(cursor_col), vecs[i].col);
      $display("vec %0d byte=%02h row=%0d col=%0d", i, vecs[i].b, cursor_row, cursor_col);
    end
    chk("vec_sb_empty", sb.size(), 0);

    // Column wrap
    do_reset();
    for (int i = 0; i < 81; i++) expect_wr(i, 8'h78);
    for (int i = 0; i < 81; i++) send("x");
    repeat (5) @(negedge clk);
    chk("wrap_row", int'(cursor_row), 1);
    chk("wrap_col", int'(cursor_col), 1);
    chk("wrap_sb_empty", sb.size(), 0);

    // Scroll at bottom row
    do_reset();
    send(8'h1B); send_str("[30H");
    repeat (3) @(negedge clk);
    chk("scroll_pre_row", int'(cursor_row), 29);
    for (int i = 0; i < 80; i++) expect_wr(i, 8'h20);
    expect_wr(0, 8'h5A);
    busy_cnt = 0;
    send(8'h0A);
    n = 0;
    while (!wr_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("scroll_first_wr", int'(wr_en), 1);
    chk("scroll_top_row", int'(top_row), 1);
    chk("scroll_busy_rise", int'(busy), 1);
    wait_busy_low(200);
    chk("scroll_busy_cycles", busy_cnt, 80);
    send("Z");
    repeat (3) @(negedge clk);
    chk("scroll_z_col", int'(cursor_col), 1);
    chk("scroll_sb_empty", sb.size(), 0);

    // CSI position, clamp, zero parameter
    do_reset();
    expect_wr(329, 8'h51);
    send(8'h1B); send_str("[5;10HQ");
    repeat (3) @(negedge clk);
    chk("csi_h_col", int'(cursor_col), 10);
    send(8'h1B); send_str("[99A");
    repeat (3) @(negedge clk);
    chk("csi_up_row", int'(cursor_row), 0);
    send(8'h1B); send_str("[0C");
    repeat (3) @(negedge clk);
    chk("csi_c0_col", int'(cursor_col), 11);
    chk("csi_sb_empty", sb.size(), 0);

    // Erase display while bytes pile up in the FIFO
    do_reset();
    send(8'h1B); send_str("[3;4H");
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2400; i++) expect_wr(i, 8'h20);
    for (int i = 0; i < 16; i++) expect_wr(163 + i, 8'h61);
    busy_cnt = 0;
    send(8'h1B); send_str("[2J");
    for (int i = 0; i < 20; i++) send("a");
    chk("erase_busy_mid", int'(busy), 1);
    chk("erase_row_mid", int'(cursor_row), 2);
    chk("erase_col_mid", int'(cursor_col), 3);
    wait_busy_low(3000);
    repeat (25) @(negedge clk);
    chk("erase_busy_cycles", busy_cnt, 2400);
    chk("erase_overflow", int'(overflow), 1);
    chk("erase_top_row", int'(top_row), 0);
    chk("erase_col_after", int'(cursor_col), 19);
    chk("erase_sb_empty", sb.size(), 0);

    // Reset in the middle of a full clear
    do_reset();
    mon_en = 1'b0;
    send_str("xy");
    send(8'h1B); send_str("[2J");
    repeat (100) @(negedge clk);
    chk("midrst_busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_addr", int'(wr_addr), 0);
    chk("midrst_col", int'(cursor_col), 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wr_en) n++;
    end
    chk("midrst_no_writes", n, 0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    expect_wr(0, 8'h52);
    send("R");
    repeat (3) @(negedge clk);
    chk("midrst_after_col", int'(cursor_col), 1);
    chk("midrst_after_busy", int'(busy), 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
